// File: rtl/alu_seq_pkg.sv
// Shared constants, operation codes and types for the execute-stage ALU sequencer.
package alu_seq_pkg;

   localparam int unsigned XLEN_W = 32;
   localparam int unsigned OP_W   = 12;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Operation code layout: {alt_op, alt_imm, funct3, opcode}
   localparam logic [11:0] ALU_ADDI  = {2'b00, 3'b000, OPC_OP_IMM};
   localparam logic [11:0] ALU_SLLI  = {2'b00, 3'b001, OPC_OP_IMM};
   localparam logic [11:0] ALU_SLTI  = {2'b00, 3'b010, OPC_OP_IMM};
   localparam logic [11:0] ALU_SLTIU = {2'b00, 3'b011, OPC_OP_IMM};
   localparam logic [11:0] ALU_XORI  = {2'b00, 3'b100, OPC_OP_IMM};
   localparam logic [11:0] ALU_SRLI  = {2'b00, 3'b101, OPC_OP_IMM};
   localparam logic [11:0] ALU_SRAI  = {2'b01, 3'b101, OPC_OP_IMM};
   localparam logic [11:0] ALU_ORI   = {2'b00, 3'b110, OPC_OP_IMM};
   localparam logic [11:0] ALU_ANDI  = {2'b00, 3'b111, OPC_OP_IMM};

   localparam logic [11:0] ALU_ADD   = {2'b00, 3'b000, OPC_OP};
   localparam logic [11:0] ALU_SUB   = {2'b10, 3'b000, OPC_OP};
   localparam logic [11:0] ALU_SLL   = {2'b00, 3'b001, OPC_OP};
   localparam logic [11:0] ALU_SLT   = {2'b00, 3'b010, OPC_OP};
   localparam logic [11:0] ALU_SLTU  = {2'b00, 3'b011, OPC_OP};
   localparam logic [11:0] ALU_XOR   = {2'b00, 3'b100, OPC_OP};
   localparam logic [11:0] ALU_SRL   = {2'b00, 3'b101, OPC_OP};
   localparam logic [11:0] ALU_SRA   = {2'b10, 3'b101, OPC_OP};
   localparam logic [11:0] ALU_OR    = {2'b00, 3'b110, OPC_OP};
   localparam logic [11:0] ALU_AND   = {2'b00, 3'b111, OPC_OP};

   localparam logic [11:0] ALU_BEQ   = {2'b00, 3'b000, OPC_BRANCH};
   localparam logic [11:0] ALU_BNE   = {2'b00, 3'b001, OPC_BRANCH};
   localparam logic [11:0] ALU_BLT   = {2'b00, 3'b100, OPC_BRANCH};
   localparam logic [11:0] ALU_BGE   = {2'b00, 3'b101, OPC_BRANCH};
   localparam logic [11:0] ALU_BLTU  = {2'b00, 3'b110, OPC_BRANCH};
   localparam logic [11:0] ALU_BGEU  = {2'b00, 3'b111, OPC_BRANCH};

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

   typedef enum logic [1:0] {KIND_OP, KIND_OP_IMM, KIND_BRANCH, KIND_ILLEGAL} kind_t;

   typedef struct packed {
      logic [OP_W-1:0]   operation;
      logic [XLEN_W-1:0] imm;
      logic [XLEN_W-1:0] b_imm;
      kind_t             kind;
      logic              legal;
   } dec_t;

endpackage

// File: rtl/alu_seq_if.sv
// Instruction, ALU-drive and response signals of the sequencer, with DUT (slave) and environment (master) views.
interface alu_seq_if;
   import alu_seq_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [XLEN_W-1:0] in_rs1_val;
   logic [XLEN_W-1:0] in_rs2_val;
   logic [XLEN_W-1:0] in_pc;

   logic [OP_W-1:0]   alu_operation;
   logic [XLEN_W-1:0] alu_rs1;
   logic [XLEN_W-1:0] alu_rs2;
   logic [XLEN_W-1:0] alu_imm;
   logic [XLEN_W-1:0] alu_rd;
   logic              alu_zero;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN_W-1:0] out_result;
   logic [4:0]        out_rd_addr;
   logic              out_rd_we;
   logic              out_branch_taken;
   logic [XLEN_W-1:0] out_branch_target;
   logic              out_illegal;

   modport slave (
      input  in_valid, in_instr, in_rs1_val, in_rs2_val, in_pc,
      input  alu_rd, alu_zero, out_ready,
      output in_ready, alu_operation, alu_rs1, alu_rs2, alu_imm,
      output out_valid, out_result, out_rd_addr, out_rd_we,
      output out_branch_taken, out_branch_target, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_rs1_val, in_rs2_val, in_pc,
      output alu_rd, alu_zero, out_ready,
      input  in_ready, alu_operation, alu_rs1, alu_rs2, alu_imm,
      input  out_valid, out_result, out_rd_addr, out_rd_we,
      input  out_branch_taken, out_branch_target, out_illegal
   );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into the ALU operation code, I-immediate, B-immediate and instruction kind.
module alu_op_decode
   import alu_seq_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            alt_op;
   logic            alt_imm;
   logic [OP_W-1:0] op_code;
   logic            unused_rs1_field;

   // Register-source field is consumed upstream by the register file
   assign unused_rs1_field = ^instr[19:15];

   always_comb begin
      opcode  = instr[6:0];
      funct3  = instr[14:12];
      alt_op  = (opcode == OPC_OP) && ((funct3 == 3'b000) || (funct3 == 3'b101)) && instr[30];
      alt_imm = (opcode == OPC_OP_IMM) && (funct3 == 3'b101) && instr[30];
      op_code = {alt_op, alt_imm, funct3, opcode};

      dec           = '0;
      dec.kind      = KIND_ILLEGAL;
      dec.operation = op_code;
      dec.b_imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

      case (op_code)
         ALU_ADDI, ALU_SLLI, ALU_SLTI, ALU_SLTIU, ALU_XORI,
         ALU_SRLI, ALU_SRAI, ALU_ORI, ALU_ANDI: begin
            dec.kind  = KIND_OP_IMM;
            dec.legal = 1'b1;
            dec.imm   = {{20{instr[31]}}, instr[31:20]};
         end
         ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
         ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: begin
            dec.kind  = KIND_OP;
            dec.legal = 1'b1;
         end
         ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
            dec.kind  = KIND_BRANCH;
            dec.legal = 1'b1;
         end
         default: begin
            dec.kind  = KIND_ILLEGAL;
            dec.legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage sequencer: accepts one instruction, steps the registered ALU through
// its one-cycle latency and presents a held response with its own handshake.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter bit          ZERO_X0 = 1'b1
)(
   input  logic     clk,
   input  logic     reset,
   alu_seq_if.slave bus
);

   state_t          state, state_nxt;
   dec_t            dec;

   logic            in_ready_q;
   logic            out_valid_q;
   logic            is_branch_q, is_branch_nxt;
   logic [OP_W-1:0] op_q, op_nxt;
   logic [XLEN-1:0] rs1_q, rs1_nxt;
   logic [XLEN-1:0] rs2_q, rs2_nxt;
   logic [XLEN-1:0] imm_q, imm_nxt;
   logic [XLEN-1:0] result_q, result_nxt;
   logic [4:0]      rd_addr_q, rd_addr_nxt;
   logic            rd_we_q, rd_we_nxt;
   logic            taken_q, taken_nxt;
   logic [XLEN-1:0] target_q, target_nxt;
   logic            illegal_q, illegal_nxt;

   alu_op_decode u_decode (
      .instr (bus.in_instr),
      .dec   (dec)
   );

   // Next-state and next-value logic; every register holds unless a state updates it
   always_comb begin
      state_nxt     = state;
      is_branch_nxt = is_branch_q;
      op_nxt        = op_q;
      rs1_nxt       = rs1_q;
      rs2_nxt       = rs2_q;
      imm_nxt       = imm_q;
      result_nxt    = result_q;
      rd_addr_nxt   = rd_addr_q;
      rd_we_nxt     = rd_we_q;
      taken_nxt     = taken_q;
      target_nxt    = target_q;
      illegal_nxt   = illegal_q;

      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               rd_addr_nxt   = bus.in_instr[11:7];
               target_nxt    = bus.in_pc + dec.b_imm;
               result_nxt    = '0;
               taken_nxt     = 1'b0;
               is_branch_nxt = (dec.kind == KIND_BRANCH);
               if (dec.legal) begin
                  op_nxt      = dec.operation;
                  rs1_nxt     = bus.in_rs1_val;
                  rs2_nxt     = bus.in_rs2_val;
                  imm_nxt     = dec.imm;
                  rd_we_nxt   = (dec.kind != KIND_BRANCH) &&
                                !(ZERO_X0 && (bus.in_instr[11:7] == 5'd0));
                  illegal_nxt = 1'b0;
                  state_nxt   = ISSUE;
               end else begin
                  rd_we_nxt   = 1'b0;
                  illegal_nxt = 1'b1;
                  state_nxt   = RESP;
               end
            end
         end
         ISSUE: state_nxt = CAPT;
         CAPT: begin
            // alu_zero is only meaningful for branches; the ALU leaves it stale otherwise
            result_nxt = bus.alu_rd;
            if (is_branch_q) taken_nxt = bus.alu_zero;
            state_nxt = RESP;
         end
         RESP: begin
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         is_branch_q <= 1'b0;
         op_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
         result_q    <= '0;
         rd_addr_q   <= '0;
         rd_we_q     <= 1'b0;
         taken_q     <= 1'b0;
         target_q    <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         in_ready_q  <= (state_nxt == IDLE);
         out_valid_q <= (state_nxt == RESP);
         is_branch_q <= is_branch_nxt;
         op_q        <= op_nxt;
         rs1_q       <= rs1_nxt;
         rs2_q       <= rs2_nxt;
         imm_q       <= imm_nxt;
         result_q    <= result_nxt;
         rd_addr_q   <= rd_addr_nxt;
         rd_we_q     <= rd_we_nxt;
         taken_q     <= taken_nxt;
         target_q    <= target_nxt;
         illegal_q   <= illegal_nxt;
      end
   end

   assign bus.in_ready          = in_ready_q;
   assign bus.out_valid         = out_valid_q;
   assign bus.alu_operation     = op_q;
   assign bus.alu_rs1           = rs1_q;
   assign bus.alu_rs2           = rs2_q;
   assign bus.alu_imm           = imm_q;
   assign bus.out_result        = result_q;
   assign bus.out_rd_addr       = rd_addr_q;
   assign bus.out_rd_we         = rd_we_q;
   assign bus.out_branch_taken  = taken_q;
   assign bus.out_branch_target = target_q;
   assign bus.out_illegal       = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq with a registered ALU model and an ISA-level reference.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   alu_seq_if bus ();

   alu_seq #(.XLEN(32), .ZERO_X0(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] int_op(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic br_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Registered ALU: one-cycle latency, zero flag only refreshed by branch operations
   always @(posedge clk) begin
      if (reset) begin
         bus.alu_rd   <= '0;
         bus.alu_zero <= 1'b0;
      end else if (bus.alu_operation[6:0] == OPC_BRANCH) begin
         bus.alu_rd   <= '0;
         bus.alu_zero <= br_cond(bus.alu_operation[9:7], bus.alu_rs1, bus.alu_rs2);
      end else begin
         bus.alu_rd <= int_op(bus.alu_operation[9:7], bus.alu_operation[11] | bus.alu_operation[10],
                              bus.alu_rs1,
                              (bus.alu_operation[6:0] == OPC_OP_IMM) ? bus.alu_imm : bus.alu_rs2);
      end
   end

   // ISA-level expectation for one instruction
   task automatic ref_model(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, output logic legal, output logic is_br,
                            output logic [31:0] res, output logic we, output logic taken,
                            output logic [31:0] tgt, output logic [31:0] imm, output logic [11:0] op);
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        alt;
      logic [12:0] boff;
      opc   = instr[6:0];
      f3    = instr[14:12];
      boff  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      tgt   = pc + 32'($signed(boff));
      legal = 1'b0; is_br = 1'b0; res = '0; we = 1'b0; taken = 1'b0; imm = '0;
      op    = {2'b00, f3, opc};
      if (opc == OPC_OP) begin
         alt   = instr[30] && (f3 == 3'd0 || f3 == 3'd5);
         op[11] = alt;
         legal = 1'b1;
         res   = int_op(f3, alt, a, b);
         we    = (instr[11:7] != 5'd0);
      end else if (opc == OPC_OP_IMM) begin
         alt   = instr[30] && (f3 == 3'd5);
         op[10] = alt;
         legal = 1'b1;
         imm   = 32'($signed(instr[31:20]));
         res   = int_op(f3, alt, a, imm);
         we    = (instr[11:7] != 5'd0);
      end else if (opc == OPC_BRANCH && f3 != 3'd2 && f3 != 3'd3) begin
         legal = 1'b1;
         is_br = 1'b1;
         taken = br_cond(f3, a, b);
      end
   endtask

   task automatic check_resp(input logic legal, input logic is_br, input logic [31:0] instr,
                             input logic [31:0] res, input logic we, input logic taken, input logic [31:0] tgt);
      chk("out_valid", bus.out_valid, 1);
      chk("in_ready_busy", bus.in_ready, 0);
      chk("out_illegal", bus.out_illegal, !legal);
      chk("out_result", bus.out_result, res);
      chk("out_rd_we", bus.out_rd_we, we);
      chk("out_branch_taken", bus.out_branch_taken, taken);
      if (legal && !is_br) chk("out_rd_addr", bus.out_rd_addr, instr[11:7]);
      if (is_br) chk("out_branch_target", bus.out_branch_target, tgt);
   endtask

   // One full transaction: accept, latency, response held for 'hold' cycles, then transfer
   task automatic run_txn(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input int hold, input logic intrude);
      logic legal, is_br, we, taken, seen;
      logic [31:0] res, tgt, imm;
      logic [11:0] op, op_before, op_hold;
      int lat;
      ref_model(instr, a, b, pc, legal, is_br, res, we, taken, tgt, imm, op);
      @(negedge clk);
      chk("in_ready_idle", bus.in_ready, 1);
      op_before = bus.alu_operation;
      op_hold   = legal ? op : op_before;
      bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_rs1_val = a; bus.in_rs2_val = b; bus.in_pc = pc;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 8) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk("alu_operation", bus.alu_operation, op_hold);
            if (legal) begin
               chk("alu_imm", bus.alu_imm, imm);
               chk("alu_rs1", bus.alu_rs1, a);
               chk("alu_rs2", bus.alu_rs2, b);
            end
         end
         seen = bus.out_valid;
      end
      chk("latency", lat, legal ? 3 : 1);
      check_resp(legal, is_br, instr, res, we, taken, tgt);
      for (int h = 0; h < hold; h++) begin
         if (intrude) begin
            bus.in_valid = 1'b1; bus.in_instr = 32'h40208233;
            bus.in_rs1_val = $urandom; bus.in_rs2_val = $urandom;
         end
         @(negedge clk);
         check_resp(legal, is_br, instr, res, we, taken, tgt);
         chk("alu_op_hold", bus.alu_operation, op_hold);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("out_valid_drop", bus.out_valid, 0);
      chk("in_ready_back", bus.in_ready, 1);
      chk("alu_op_after", bus.alu_operation, op_hold);
   endtask

   initial begin
      logic [31:0] instr, a, b;
      int sel;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_rs1_val = '0; bus.in_rs2_val = '0;
      bus.in_pc = '0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_alu_operation", bus.alu_operation, 0);
      chk("rst_alu_rs1", bus.alu_rs1, 0);
      chk("rst_alu_rs2", bus.alu_rs2, 0);
      chk("rst_alu_imm", bus.alu_imm, 0);
      chk("rst_out_result", bus.out_result, 0);
      chk("rst_out_rd_addr", bus.out_rd_addr, 0);
      chk("rst_out_rd_we", bus.out_rd_we, 0);
      chk("rst_out_taken", bus.out_branch_taken, 0);
      chk("rst_out_target", bus.out_branch_target, 0);
      chk("rst_out_illegal", bus.out_illegal, 0);

      run_txn(32'hFFD08293, 32'd10, 32'd0, 32'h0, 0, 1'b0);          // addi x5,x1,-3
      run_txn(32'h402081B3, 32'd5, 32'd7, 32'h0, 1, 1'b0);           // sub x3,x1,x2
      run_txn(32'h00208463, 32'd4, 32'd4, 32'h100, 0, 1'b0);         // beq taken
      run_txn(32'h00208463, 32'd4, 32'd5, 32'h100, 0, 1'b0);         // beq not taken
      run_txn(32'h4040D213, 32'hF00, 32'd0, 32'h0, 2, 1'b0);         // srai x4,x1,4
      run_txn(32'h0000007F, 32'd1, 32'd2, 32'h0, 5, 1'b1);           // illegal, held response

      // Reset while the ALU result is being captured
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_instr = 32'hFFD08293; bus.in_rs1_val = 32'd10;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("capt_rst_out_valid", bus.out_valid, 0);
      chk("capt_rst_in_ready", bus.in_ready, 1);
      chk("capt_rst_alu_operation", bus.alu_operation, 0);
      chk("capt_rst_alu_rs1", bus.alu_rs1, 0);
      chk("capt_rst_alu_imm", bus.alu_imm, 0);
      run_txn(32'hFFD08293, 32'd10, 32'd0, 32'h0, 0, 1'b0);

      for (int t = 0; t < 200; t++) begin
         sel   = int'($urandom_range(0, 9));
         instr = $urandom;
         if (sel < 3)      instr[6:0] = OPC_OP;
         else if (sel < 6) instr[6:0] = OPC_OP_IMM;
         else if (sel < 9) instr[6:0] = OPC_BRANCH;
         if ($urandom_range(0, 7) == 0) instr[11:7] = 5'd0;
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         run_txn(instr, a, b, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
